// File: rtl/seq_mult_8_bit_if.sv
// Handshake and operand/result bundle for the sequential signed-magnitude multiplier.
interface seq_mult_8_bit_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a_mag;
    logic             a_sign;
    logic [WIDTH-1:0] b_mag;
    logic             b_sign;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] prod_hi;
    logic [WIDTH-1:0] prod_lo;
    logic             prod_sign;
    logic             load_hi;
    logic             load_lo;

    modport master (
        output start, a_mag, a_sign, b_mag, b_sign,
        input  busy, done, prod_hi, prod_lo, prod_sign,
        input  load_hi, load_lo
    );

    modport slave (
        input  start, a_mag, a_sign, b_mag, b_sign,
        output busy, done, prod_hi, prod_lo, prod_sign,
        output load_hi, load_lo
    );
endinterface

// File: rtl/seq_mult_8_bit.sv
// Sequential signed-magnitude shift-and-add multiplier, one multiplier bit per clock.
// Optional ZERO_SKIP_EN: a zero operand bypasses CALC and finishes in one cycle.
module seq_mult_8_bit #(
    parameter int WIDTH = 8
) (
    input  logic            clk,
    input  logic            reset,
    seq_mult_8_bit_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] m;
    logic [CW-1:0]    count;
    logic             sgn;
    logic [WIDTH-1:0] prod_hi_r;
    logic [WIDTH-1:0] prod_lo_r;
    logic             prod_sign_r;

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] acc_n;
    logic [WIDTH-1:0] q_n;
    logic             last;
    logic             zero_op;

    // Carry of the add lands in sum[WIDTH] and is shifted straight into acc.
    always_comb begin
        sum   = {1'b0, acc} + (q[0] ? {1'b0, m} : '0);
        acc_n = sum[WIDTH:1];
        q_n   = {sum[0], q[WIDTH-1:1]};
        last  = (count == LAST);
`ifdef ZERO_SKIP_EN
        zero_op = (bus.a_mag == '0) || (bus.b_mag == '0);
`else
        zero_op = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (bus.start) state_n = zero_op ? DONE : CALC;
            end
            CALC: begin
                if (last) state_n = DONE;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Product registers load only on the final iteration, so they
    // never expose partial ACC/Q values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc         <= '0;
            q           <= '0;
            m           <= '0;
            count       <= '0;
            sgn         <= 1'b0;
            prod_hi_r   <= '0;
            prod_lo_r   <= '0;
            prod_sign_r <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        m     <= bus.a_mag;
                        q     <= bus.b_mag;
                        acc   <= '0;
                        count <= '0;
                        sgn   <= bus.a_sign ^ bus.b_sign;
                        if (zero_op) begin
                            prod_hi_r   <= '0;
                            prod_lo_r   <= '0;
                            prod_sign_r <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    acc   <= acc_n;
                    q     <= q_n;
                    count <= count + 1'b1;
                    if (last) begin
                        prod_hi_r   <= acc_n;
                        prod_lo_r   <= q_n;
                        prod_sign_r <= sgn & (|{acc_n, q_n});
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.busy      = (state != IDLE);
        bus.done      = (state == DONE);
        bus.load_hi   = (state == DONE);
        bus.load_lo   = (state == DONE);
        bus.prod_hi   = prod_hi_r;
        bus.prod_lo   = prod_lo_r;
        bus.prod_sign = prod_sign_r;
    end
endmodule
